// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Width of a counter or index covering values 0 .. n-1 (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester after last_grant_i, wrapping.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_req_o
);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] sel;
        grant_o   = '0;
        any_req_o = 1'b0;
        idx       = 0;
        sel       = '0;
        // Walk last_grant+1 .. last_grant+NUM_REQ so the previous winner is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (!any_req_o && req_i[sel]) begin
                any_req_o = 1'b1;
                grant_o   = sel;
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// Optional WAIT-state timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MEMORY_WIDTH   = 32,
    parameter int MEMORY_DEPTH   = 256,
    parameter int ADDRESS_WIDTH  = $clog2(MEMORY_DEPTH),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0]                req_wr_i,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*MEMORY_WIDTH-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [MEMORY_WIDTH-1:0]           rsp_rdata_o,
    output logic                              rsp_err_o,
    output logic                              mem_valid_o,
    output logic                              mem_wr_rd_o,
    output logic [ADDRESS_WIDTH-1:0]          mem_addr_o,
    output logic [MEMORY_WIDTH-1:0]           mem_wdata_o,
    input  logic                              mem_ready_i,
    input  logic [MEMORY_WIDTH-1:0]           mem_rdata_i
);

    localparam int IDX_W = cnt_width(NUM_REQ);

    arb_state_e                 state_q;
    logic [IDX_W-1:0]           last_grant_q;
    logic [IDX_W-1:0]           grant_q;
    logic                       wr_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [MEMORY_WIDTH-1:0]    wdata_q;
    logic [MEMORY_WIDTH-1:0]    rdata_q;
    logic                       mem_valid_q;
    logic [NUM_REQ-1:0]         req_ready_q;

    logic [IDX_W-1:0]           pick_idx;
    logic                       any_req;
    logic                       wr_d;
    logic [ADDRESS_WIDTH-1:0]   addr_d;
    logic [MEMORY_WIDTH-1:0]    wdata_d;
    logic                       timeout;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .any_req_o    (any_req)
    );

    always_comb begin
        wr_d    = req_wr_i[pick_idx];
        addr_d  = req_addr_i[int'(pick_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        wdata_d = req_wdata_i[int'(pick_idx)*MEMORY_WIDTH +: MEMORY_WIDTH];
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                CNT_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Counter reaches CNT_LAST on the TIMEOUT_CYCLES-th WAIT cycle.
    assign timeout = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (!mem_ready_i && timeout) begin
                    err_q <= 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rsp_err_o = err_q;
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mem_valid_q  <= 1'b0;
            req_ready_q  <= '0;
        end else begin
            mem_valid_q <= 1'b0;
            req_ready_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q      <= pick_idx;
                        last_grant_q <= pick_idx;
                        wr_q         <= wr_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        mem_valid_q  <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A memory response on the final WAIT cycle wins over the timeout.
                    if (mem_ready_i || timeout) begin
                        if (mem_ready_i && !wr_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        req_ready_q[grant_q] <= 1'b1;
                        state_q              <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_rdata_o = rdata_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_wr_rd_o = wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule
